// File: rtl/fetch_align.sv
// Instruction fetch/align: streams imem words into a byte queue and presents one
// MIPS or Y86 instruction per handshake. Optional trap on Y86 D-F opcodes: FETCH_ILLEGAL_TRAP_EN.
module fetch_align #(
  parameter int unsigned BUF_BYTES  = 12,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic        RESET_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_mode,
  output logic [47:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] next_inst_pc,
  output logic        mode,
  output logic        inst_valid,
  output logic        illegal
);

  localparam int unsigned CW = $clog2(BUF_BYTES + 1);
  localparam int unsigned QW = 8 * BUF_BYTES;
  localparam logic [CW:0] BUF_LIM = (CW+1)'(BUF_BYTES);

  typedef logic [CW-1:0] cnt_t;

  logic [QW-1:0] q_q, q_d;
  cnt_t          count_q, count_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic          mode_q, mode_d;
  logic          inflight_q, inflight_d;
  logic          discard_q, discard_d;
  logic [1:0]    skip_q, skip_d;
  logic          run_q, run_d;

  logic [3:0]    nib;
  logic [2:0]    len;
  cnt_t          len_c;
  cnt_t          cnt_pop;
  logic [CW:0]   need;
  logic          wedge, trap, pop, append;
  logic [QW-1:0] q_pop, app_word;

  assign nib = q_q[7:4];

  always_comb begin
    len = 3'd1;
    if (!mode_q) begin
      len = 3'd4;
    end else begin
      case (nib)
        4'h0, 4'h1, 4'h9:        len = 3'd1;
        4'h2, 4'h6, 4'hA, 4'hB:  len = 3'd2;
        4'h7, 4'h8, 4'hC:        len = 3'd5;
        4'h3, 4'h4, 4'h5:        len = 3'd6;
        default:                 len = 3'd1;
      endcase
    end
  end

  assign len_c = cnt_t'(len);
  // A misaligned MIPS pc can never be decoded; hold off until redirected
  assign wedge = !mode_q && (pc_q[1:0] != 2'b00);
  assign inst_valid = (count_q >= len_c) && !discard_q && !wedge;

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign trap    = mode_q && (nib >= 4'hD);
  assign illegal = inst_valid && trap;
`else
  assign trap    = 1'b0;
  assign illegal = 1'b0;
`endif

  assign pop     = inst_valid && !stall && !redirect && !trap;
  assign cnt_pop = pop ? (count_q - len_c) : count_q;
  assign need    = {1'b0, cnt_pop} + (inflight_q ? (CW+1)'(8) : (CW+1)'(4));
  assign imem_req  = run_q && (need <= BUF_LIM);
  assign imem_addr = fetch_addr_q;
  assign append    = inflight_q && !discard_q;

  assign inst         = q_q[47:0] & ~({48{1'b1}} << {len, 3'b000});
  assign inst_pc      = pc_q;
  assign next_inst_pc = pc_q + 32'(len);
  assign mode         = mode_q;

  // Bytes at and above count are kept zero, so appending is a shifted OR
  assign q_pop    = pop ? (q_q >> {len, 3'b000}) : q_q;
  assign app_word = QW'(imem_rdata >> {skip_q, 3'b000});

  always_comb begin
    run_d        = 1'b1;
    inflight_d   = imem_req;
    discard_d    = 1'b0;
    mode_d       = mode_q;
    pc_d         = pop ? (pc_q + 32'(len)) : pc_q;
    fetch_addr_d = imem_req ? (fetch_addr_q + 32'd4) : fetch_addr_q;
    q_d          = append ? (q_pop | (app_word << {cnt_pop, 3'b000})) : q_pop;
    count_d      = cnt_pop + (append ? cnt_t'(3'd4 - {1'b0, skip_q}) : '0);
    skip_d       = append ? 2'b00 : skip_q;
    if (redirect) begin
      pc_d         = redirect_pc;
      mode_d       = redirect_mode;
      count_d      = '0;
      q_d          = '0;
      fetch_addr_d = {redirect_pc[31:2], 2'b00};
      skip_d       = redirect_pc[1:0];
      discard_d    = imem_req;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_q          <= '0;
      count_q      <= '0;
      pc_q         <= RESET_PC;
      mode_q       <= RESET_MODE;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      skip_q       <= RESET_PC[1:0];
      inflight_q   <= 1'b0;
      discard_q    <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      q_q          <= q_d;
      count_q      <= count_d;
      pc_q         <= pc_d;
      mode_q       <= mode_d;
      fetch_addr_q <= fetch_addr_d;
      skip_q       <= skip_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      run_q        <= run_d;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: fixed-latency memory model, per-scenario tasks
// with hand-computed expectations. Inputs are driven and outputs sampled on negedge.
module tb_fetch_align;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        redirect_mode;
  logic [47:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] next_inst_pc;
  logic        mode;
  logic        inst_valid;
  logic        illegal;

  logic [31:0] mem [256];
  int unsigned tests_run = 0;
  int unsigned fails = 0;

  fetch_align #(.BUF_BYTES(12), .RESET_PC(32'h0), .RESET_MODE(1'b0)) dut (
    .clk(clk), .resetn(resetn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .redirect_mode(redirect_mode), .inst(inst),
    .inst_pc(inst_pc), .next_inst_pc(next_inst_pc), .mode(mode),
    .inst_valid(inst_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr[9:2]];
  end

  task automatic do_redirect(input logic [31:0] pc, input logic md, input logic st);
    redirect = 1'b1; redirect_pc = pc; redirect_mode = md; stall = st;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; stall = 1'b1; redirect = 1'b0; redirect_pc = '0; redirect_mode = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({inst_valid, imem_req, illegal} !== 3'b000 || inst !== 48'h0) begin
      fails++; $display("FAIL reset_outputs: valid/req/ill=%b inst=%h, required 000 / 0", {inst_valid, imem_req, illegal}, inst);
    end
    resetn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL first_req: req=%b addr=%h, required 1 / 00000000", imem_req, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0) begin
      fails++; $display("FAIL first_latency: inst_valid=%b, required 0", inst_valid);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst !== 48'h0000_2001_0005 || inst_pc !== 32'h0 ||
        next_inst_pc !== 32'h4 || mode !== 1'b0) begin
      fails++; $display("FAIL first_inst: v=%b inst=%h pc=%h npc=%h mode=%b, required 1 000020010005 0 4 0",
                        inst_valid, inst, inst_pc, next_inst_pc, mode);
    end
  endtask

  task automatic test_stall;
    logic [31:0] exp_pc;
    logic [47:0] exp_inst;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b1 || inst !== 48'h0000_2001_0005 || inst_pc !== 32'h0) begin
        fails++; $display("FAIL stall_hold[%0d]: v=%b inst=%h pc=%h, required 1 000020010005 0", c, inst_valid, inst, inst_pc);
      end
    end
    tests_run++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL stall_full_noreq: imem_req=%b, required 0", imem_req);
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(k * 4);
      exp_inst = {16'h0, mem[k]};
      tests_run++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== exp_inst) begin
        fails++; $display("FAIL stall_drain[%0d]: v=%b pc=%h inst=%h, required 1 %h %h", k, inst_valid, inst_pc, inst, exp_pc, exp_inst);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect;
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (imem_req === 1'b1) seen = 1;
      else @(negedge clk);
    end
    tests_run++;
    if (!seen) begin
      fails++; $display("FAIL redirect_wait_req: imem_req never 1 within 20 cycles, required 1");
    end
    do_redirect(32'h0000_0102, 1'b1, 1'b1);
    tests_run++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      fails++; $display("FAIL redirect_next: v=%b req=%b addr=%h, required 0 1 00000100", inst_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h104) begin
      fails++; $display("FAIL redirect_discard: v=%b addr=%h, required 0 00000104", inst_valid, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h102 || inst !== 48'h10 ||
        next_inst_pc !== 32'h103 || mode !== 1'b1) begin
      fails++; $display("FAIL redirect_first: v=%b pc=%h inst=%h npc=%h mode=%b, required 1 102 10 103 1",
                        inst_valid, inst_pc, inst, next_inst_pc, mode);
    end
  endtask

  task automatic test_y86_stream;
    logic [31:0] got_pc [4];
    logic [31:0] got_len [4];
    logic [47:0] got_inst [4];
    logic [31:0] exp_pc [4];
    logic [31:0] exp_len [4];
    int n = 0;
    exp_pc[0] = 32'd0; exp_pc[1] = 32'd1; exp_pc[2] = 32'd3; exp_pc[3] = 32'd9;
    exp_len[0] = 32'd1; exp_len[1] = 32'd2; exp_len[2] = 32'd6; exp_len[3] = 32'd1;
    mem[0] = 32'h3012_2010; mem[1] = 32'h3456_78F3; mem[2] = 32'h0000_9012;
    do_redirect(32'h0, 1'b1, 1'b0);
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (inst_valid === 1'b1) begin
        got_pc[n] = inst_pc; got_len[n] = next_inst_pc - inst_pc; got_inst[n] = inst;
        n++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (n != 4) begin
      fails++; $display("FAIL y86_count: %0d instructions seen, required 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_pc[i] !== exp_pc[i] || got_len[i] !== exp_len[i]) begin
          fails++; $display("FAIL y86_inst[%0d]: pc=%h len=%0d, required %h %0d", i, got_pc[i], got_len[i], exp_pc[i], exp_len[i]);
        end
      end
      tests_run++;
      if (got_inst[2] !== 48'h1234_5678_F330 || got_inst[1] !== 48'h1220) begin
        fails++; $display("FAIL y86_bytes: irmovl=%h rrmovl=%h, required 12345678f330 1220", got_inst[2], got_inst[1]);
      end
    end
  endtask

  task automatic test_wrap;
    mem[255] = 32'h1220_0000;
    do_redirect(32'hFFFF_FFFE, 1'b1, 1'b1);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL wrap_req0: req=%b addr=%h, required 1 fffffffc", imem_req, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL wrap_req1: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst !== 48'h1220 || inst_pc !== 32'hFFFF_FFFE || next_inst_pc !== 32'h0) begin
      fails++; $display("FAIL wrap_inst: v=%b inst=%h pc=%h npc=%h, required 1 1220 fffffffe 0", inst_valid, inst, inst_pc, next_inst_pc);
    end
  endtask

  task automatic test_mips_wedge;
    bit bad = 0;
    do_redirect(32'h0000_0102, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      if (inst_valid !== 1'b0) bad = 1;
      @(negedge clk);
    end
    tests_run++;
    if (bad || inst_pc !== 32'h102) begin
      fails++; $display("FAIL mips_wedge: valid_seen=%0d pc=%h, required 0 102", bad, inst_pc);
    end
  endtask

  task automatic test_illegal;
    bit seen = 0;
    mem[0] = 32'h0000_10E0;
    do_redirect(32'h0, 1'b1, 1'b0);
    for (int c = 0; c < 10 && !seen; c++) begin
      if (inst_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    tests_run++;
    if (!seen || inst !== 48'hE0 || inst_pc !== 32'h0) begin
      fails++; $display("FAIL illegal_present: seen=%0d inst=%h pc=%h, required 1 e0 0", seen, inst, inst_pc);
    end
`ifdef FETCH_ILLEGAL_TRAP_EN
    tests_run++;
    if (illegal !== 1'b1) begin
      fails++; $display("FAIL illegal_flag: illegal=%b, required 1", illegal);
    end
    @(negedge clk);
    tests_run++;
    if (illegal !== 1'b1 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      fails++; $display("FAIL illegal_hold: ill=%b v=%b pc=%h, required 1 1 0", illegal, inst_valid, inst_pc);
    end
    do_redirect(32'h100, 1'b1, 1'b0);
    tests_run++;
    if (illegal !== 1'b0) begin
      fails++; $display("FAIL illegal_clear: illegal=%b, required 0", illegal);
    end
`else
    tests_run++;
    if (illegal !== 1'b0 || next_inst_pc !== 32'h1) begin
      fails++; $display("FAIL illegal_as_nop: ill=%b npc=%h, required 0 1", illegal, next_inst_pc);
    end
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h1 || inst !== 48'h10) begin
      fails++; $display("FAIL illegal_consumed: v=%b pc=%h inst=%h, required 1 1 10", inst_valid, inst_pc, inst);
    end
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    tests_run++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || inst_pc !== 32'h0 || mode !== 1'b0) begin
      fails++; $display("FAIL reset_mid: v=%b req=%b pc=%h mode=%b, required 0 0 0 0", inst_valid, imem_req, inst_pc, mode);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h2001_0005;
    mem[1]  = 32'h8C22_0004;
    mem[2]  = 32'hAC22_0008;
    mem[64] = 32'h2010_BBAA;
    mem[65] = 32'h0000_0012;
    test_reset;
    test_stall;
    test_redirect;
    test_y86_stream;
    test_wrap;
    test_mips_wedge;
    test_illegal;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
